brick_field_renderer: RTL and testbench

- Parametrised brick-field manager and pixel streamer for the Brick Breaker datapath; it is the successor to the fixed 40-brick RAM loader and initial draw.
- Holds a COLS x ROWS alive bitmap.
- On command, streams pixels one per cycle to the VGA adapter's x/y/colour/plot inputs. Supported operations: draw the whole field, erase one brick, revive one brick.
- Provides a combinational point-hit query, so ball logic can detect brick collisions without touching the frame buffer.

---
 rtl/brick_pkg.sv | 24 ++
 rtl/brick_pixel_scan.sv | 94 +++++++++
 rtl/brick_field_renderer.sv | 196 +++++++++++++++++++
 tb/tb_brick_field_renderer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared op codes, controller states and the per-row colour rule for the brick-field renderer.
package brick_pkg;

  typedef enum logic [1:0] {
    OP_INIT_ALL = 2'd0,
    OP_REDRAW   = 2'd1,
    OP_KILL     = 2'd2,
    OP_REVIVE   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    DRAW_ALL,
    DRAW_ONE
  } state_e;

  // Cycles through 1..2^colour_w-1 so a live brick is never drawn in colour 0.
  function automatic int unsigned row_colour(input int unsigned row, input int unsigned colour_w);
    int unsigned levels;
    levels = (32'd1 << colour_w) - 32'd1;
    return (row % levels) + 32'd1;
  endfunction

endpackage

// File: rtl/brick_pixel_scan.sv
// Nested brick/px/py walker. The current position is combinational so the first pixel
// is available in the same cycle the scan is started.
module brick_pixel_scan #(
  parameter int COLS    = 10,
  parameter int ROWS    = 4,
  parameter int BRICK_W = 16,
  parameter int BRICK_H = 4,
  parameter int IDX_W   = $clog2(COLS * ROWS),
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PXW    = (BRICK_W > 1) ? $clog2(BRICK_W) : 1,
  localparam int PYW    = (BRICK_H > 1) ? $clog2(BRICK_H) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             single,
  input  logic [IDX_W-1:0] base_idx,
  input  logic             step,
  output logic [CW-1:0]    col,
  output logic [RW-1:0]    row,
  output logic [PXW-1:0]   px,
  output logic [PYW-1:0]   py,
  output logic             last
);

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic           single_q, single_d, single_cur;

  always_comb begin
    if (start) begin
      col        = single ? CW'(int'(base_idx) % COLS) : '0;
      row        = single ? RW'(int'(base_idx) / COLS) : '0;
      px         = '0;
      py         = '0;
      single_cur = single;
    end else begin
      col        = col_q;
      row        = row_q;
      px         = px_q;
      py         = py_q;
      single_cur = single_q;
    end
    last = (px == PXW'(BRICK_W - 1)) && (py == PYW'(BRICK_H - 1)) &&
           (single_cur || ((col == CW'(COLS - 1)) && (row == RW'(ROWS - 1))));

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    col_d    = col_q;
    row_d    = row_q;
    px_d     = px_q;
    py_d     = py_q;
    single_d = single_q;
    if (step) begin
      single_d = single_cur;
      col_d    = col;
      row_d    = row;
      px_d     = px + 1'b1;
      py_d     = py;
      if (px == PXW'(BRICK_W - 1)) begin
        px_d = '0;
        py_d = py + 1'b1;
        if (py == PYW'(BRICK_H - 1)) begin
          py_d  = '0;
          col_d = col + 1'b1;
          if (col == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = row + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      single_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      px_q     <= px_d;
      py_q     <= py_d;
      single_q <= single_d;
    end
  end

endmodule

// File: rtl/brick_field_renderer.sv
// Brick-field bitmap with a one-pixel-per-cycle VGA streamer and a combinational point-hit query.
module brick_field_renderer
  import brick_pkg::*;
#(
  parameter int                  COLS         = 10,
  parameter int                  ROWS         = 4,
  parameter int                  BRICK_W      = 16,
  parameter int                  BRICK_H      = 4,
  parameter int                  ROW_PITCH    = 8,
  parameter int                  X_ORIGIN     = 0,
  parameter int                  Y_ORIGIN     = 0,
  parameter int                  X_W          = 8,
  parameter int                  Y_W          = 7,
  parameter int                  COLOUR_W     = 3,
  parameter logic [COLOUR_W-1:0] BRICK_COLOUR = 3'b100,
  parameter int                  COLOUR_MODE  = 0,
  parameter logic [COLOUR_W-1:0] BG_COLOUR    = '0,
  parameter int                  IDX_W        = $clog2(COLS * ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_W-1:0]    cmd_idx,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done,
  input  logic [X_W-1:0]      query_x,
  input  logic [Y_W-1:0]      query_y,
  output logic                query_hit,
  output logic [IDX_W-1:0]    query_idx,
  output logic [IDX_W:0]      alive_count,
  output logic                cleared
);

  localparam int N   = COLS * ROWS;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PXW = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int PYW = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d, eff_op;
  logic [N-1:0]        alive_q, alive_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d, brick_col;
  logic                plot_q, plot_d, done_q, done_d;

  logic                accept, idx_ok, draw_active, pix_alive;
  logic                scan_start, scan_single, scan_last;
  logic [CW-1:0]       scan_col;
  logic [RW-1:0]       scan_row;
  logic [PXW-1:0]      scan_px;
  logic [PYW-1:0]      scan_py;
  int                  pix_idx;
  int                  q_dx, q_dy, q_col, q_row, q_idx;
  logic                q_in;

  brick_pixel_scan #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .IDX_W(IDX_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .start   (scan_start),
    .single  (scan_single),
    .base_idx(cmd_idx),
    .step    (draw_active),
    .col     (scan_col),
    .row     (scan_row),
    .px      (scan_px),
    .py      (scan_py),
    .last    (scan_last)
  );

  always_comb begin
    accept      = cmd_valid && (state_q == IDLE);
    idx_ok      = int'(cmd_idx) < N;
    state_d     = state_q;
    op_d        = op_q;
    alive_d     = alive_q;
    count_d     = count_q;
    scan_start  = 1'b0;
    scan_single = 1'b0;
    done_d      = 1'b0;
    if (accept) begin
      op_d = op_e'(cmd_op);
      case (op_e'(cmd_op))
        OP_INIT_ALL: begin
          alive_d    = '1;
          count_d    = (IDX_W + 1)'(N);
          state_d    = DRAW_ALL;
          scan_start = 1'b1;
        end
        OP_REDRAW: begin
          state_d    = DRAW_ALL;
          scan_start = 1'b1;
        end
        default: begin
          if (idx_ok) begin
            alive_d[cmd_idx] = (cmd_op == OP_REVIVE);
            if ((cmd_op == OP_REVIVE) && !alive_q[cmd_idx]) count_d = count_q + 1'b1;
            if ((cmd_op == OP_KILL) && alive_q[cmd_idx])    count_d = count_q - 1'b1;
            state_d     = DRAW_ONE;
            scan_start  = 1'b1;
            scan_single = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      endcase
    end
    draw_active = scan_start || (state_q != IDLE);
    if (draw_active && scan_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  // In the accept cycle the op has not been registered yet, so take it from the port.
  always_comb begin
    eff_op  = (state_q == IDLE) ? op_e'(cmd_op) : op_q;
    pix_idx = int'(scan_row) * COLS + int'(scan_col);
    case (eff_op)
      OP_REDRAW: pix_alive = alive_q[IDX_W'(pix_idx)];
      OP_KILL:   pix_alive = 1'b0;
      default:   pix_alive = 1'b1;
    endcase
    brick_col = (COLOUR_MODE != 0) ? COLOUR_W'(row_colour(int'(scan_row), COLOUR_W))
                                   : BRICK_COLOUR;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = draw_active;
    if (draw_active) begin
      x_d      = X_W'(X_ORIGIN + int'(scan_col) * BRICK_W + int'(scan_px));
      y_d      = Y_W'(Y_ORIGIN + int'(scan_row) * ROW_PITCH + int'(scan_py));
      colour_d = pix_alive ? brick_col : BG_COLOUR;
    end
  end

  always_comb begin
    q_dx      = int'(query_x) - X_ORIGIN;
    q_dy      = int'(query_y) - Y_ORIGIN;
    q_col     = q_dx / BRICK_W;
    q_row     = q_dy / ROW_PITCH;
    q_idx     = q_row * COLS + q_col;
    q_in      = (q_dx >= 0) && (q_dy >= 0) && (q_col < COLS) && (q_row < ROWS) &&
                ((q_dy % ROW_PITCH) < BRICK_H);
    query_hit = 1'b0;
    query_idx = '0;
    if (q_in && alive_q[IDX_W'(q_idx)]) begin
      query_hit = 1'b1;
      query_idx = IDX_W'(q_idx);
    end
  end

  // NOTE: the bitmap is built from flops rather than a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_INIT_ALL;
      alive_q  <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      alive_q  <= alive_d;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign done        = done_q;
  assign alive_count = count_q;
  assign cleared     = (count_q == '0);

endmodule

// File: tb/tb_brick_field_renderer.sv
// Scoreboard bench: default field (a) and an 8-row per-row-colour field (b) checked against a rectangle-level model.
module tb_brick_field_renderer;
  import brick_pkg::*;

  typedef struct packed {
    bit       plot;
    bit [7:0] x;
    bit [6:0] y;
    bit [2:0] c;
    bit       done;
  } pix_t;

  logic       clk;
  logic       reset;
  logic [1:0] cmd_op;
  logic [6:0] cmd_idx_bus;
  logic       a_valid, b_valid;
  logic [7:0] query_x;
  logic [6:0] query_y;

  logic       a_ready, a_plot, a_done, a_hit, a_cleared;
  logic [7:0] a_x;
  logic [6:0] a_y;
  logic [2:0] a_c;
  logic [5:0] a_qidx;
  logic [6:0] a_count;

  logic       b_ready, b_plot, b_done, b_hit, b_cleared;
  logic [7:0] b_x;
  logic [6:0] b_y;
  logic [2:0] b_c;
  logic [6:0] b_qidx;
  logic [7:0] b_count;

  pix_t q_a[$];
  pix_t q_b[$];
  bit   alive_m[2][80];
  int   count_m[2];
  int   ncheck = 0;
  int   nerr   = 0;

  brick_field_renderer u_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx_bus[5:0]), .x(a_x), .y(a_y), .colour(a_c), .plot(a_plot), .done(a_done),
    .query_x(query_x), .query_y(query_y), .query_hit(a_hit), .query_idx(a_qidx),
    .alive_count(a_count), .cleared(a_cleared)
  );

  brick_field_renderer #(.ROWS(8), .COLOUR_MODE(1)) u_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx_bus), .x(b_x), .y(b_y), .colour(b_c), .plot(b_plot), .done(b_done),
    .query_x(query_x), .query_y(query_y), .query_hit(b_hit), .query_idx(b_qidx),
    .alive_count(b_count), .cleared(b_cleared)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rows_of(input int w);
    return (w != 0) ? 8 : 4;
  endfunction

  function automatic int colour_of(input int w, input int r, input bit alive);
    if (!alive) return 0;
    return (w != 0) ? (r % 7) + 1 : 4;
  endfunction

  task automatic push(input int w, input pix_t p);
    if (w != 0) q_b.push_back(p);
    else        q_a.push_back(p);
  endtask

  task automatic gen_brick(input int w, input int b, input bit alive, input bit last_brick);
    pix_t p;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 16; px++) begin
        p.plot = 1'b1;
        p.x    = 8'((b % 10) * 16 + px);
        p.y    = 7'((b / 10) * 8 + py);
        p.c    = 3'(colour_of(w, b / 10, alive));
        p.done = last_brick && (px == 15) && (py == 3);
        push(w, p);
      end
    end
  endtask

  // Updates the model bitmap and queues every expected output beat; returns the cycles to done.
  task automatic model_cmd(input int w, input int op, input int idx, output int len);
    int   n;
    pix_t p;
    n = 10 * rows_of(w);
    if (op == int'(OP_INIT_ALL) || op == int'(OP_REDRAW)) begin
      if (op == int'(OP_INIT_ALL)) begin
        for (int b = 0; b < n; b++) alive_m[w][b] = 1'b1;
        count_m[w] = n;
      end
      for (int b = 0; b < n; b++) gen_brick(w, b, alive_m[w][b], b == n - 1);
      len = n * 64;
    end else if (idx < n) begin
      if (op == int'(OP_REVIVE) && !alive_m[w][idx]) count_m[w]++;
      if (op == int'(OP_KILL) && alive_m[w][idx])    count_m[w]--;
      alive_m[w][idx] = (op == int'(OP_REVIVE));
      gen_brick(w, idx, op == int'(OP_REVIVE), 1'b1);
      len = 64;
    end else begin
      p      = '0;
      p.done = 1'b1;
      push(w, p);
      len = 1;
    end
  endtask

  // Hit model: the point must lie inside the drawn rectangle of some live brick.
  task automatic chk_query(input int w, input string tag);
    bit hit;
    int idx;
    int bx, by;
    hit = 1'b0;
    idx = 0;
    for (int b = 0; b < 10 * rows_of(w); b++) begin
      bx = (b % 10) * 16;
      by = (b / 10) * 8;
      if (alive_m[w][b] && int'(query_x) >= bx && int'(query_x) < bx + 16 &&
          int'(query_y) >= by && int'(query_y) < by + 4) begin
        hit = 1'b1;
        idx = b;
      end
    end
    check({tag, "_hit"}, (w != 0) ? 32'(b_hit) : 32'(a_hit), 32'(hit));
    check({tag, "_idx"}, (w != 0) ? 32'(b_qidx) : 32'(a_qidx), idx);
  endtask

  task automatic set_query(input int qx, input int qy);
    @(negedge clk);
    query_x = 8'(qx);
    query_y = 7'(qy);
    #1;
  endtask

  task automatic mon(input int w, input logic plot, input logic done, input logic [7:0] x,
                     input logic [6:0] y, input logic [2:0] c);
    pix_t        e;
    logic [19:0] act;
    if (plot !== 1'b1 && done !== 1'b1) return;
    if (((w != 0) ? q_b.size() : q_a.size()) == 0) begin
      ncheck++;
      nerr++;
      $display("FAIL unexpected_output_%0d: got plot=%b done=%b x=%0d y=%0d expected nothing",
               w, plot, done, x, y);
      return;
    end
    e   = (w != 0) ? q_b.pop_front() : q_a.pop_front();
    act = {plot, x, y, c, done};
    if (!e.plot) act = {plot, 8'd0, 7'd0, 3'd0, done};
    check((w != 0) ? "pixel_b" : "pixel_a", 32'(act), 32'(e));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon(0, a_plot, a_done, a_x, a_y, a_c);
      mon(1, b_plot, b_done, b_x, b_y, b_c);
    end
  end

  task automatic issue(input int w, input int op, input int idx);
    int len, c, plots;
    bit got_done;
    c = 0;
    while (((w != 0) ? b_ready : a_ready) !== 1'b1 && c < 6000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("ready_before_cmd", (w != 0) ? 32'(b_ready) : 32'(a_ready), 1);
    @(negedge clk);
    model_cmd(w, op, idx, len);
    cmd_op      = 2'(op);
    cmd_idx_bus = 7'(idx);
    if (w != 0) b_valid = 1'b1;
    else        a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    c        = 1;
    plots    = 0;
    got_done = 1'b0;
    while (c <= len + 4) begin
      if (c == 1) chk_query(w, "q_after_accept");
      if (((w != 0) ? b_plot : a_plot) === 1'b1) plots++;
      if (((w != 0) ? b_done : a_done) === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      c++;
    end
    check("done_cycle", got_done ? c : -1, len);
    check("plot_cycles", plots, (len == 1) ? 0 : len);
    @(negedge clk);
    check("queue_drained", (w != 0) ? q_b.size() : q_a.size(), 0);
    check("alive_count", (w != 0) ? 32'(b_count) : 32'(a_count), count_m[w]);
    check("cleared", (w != 0) ? 32'(b_cleared) : 32'(a_cleared), 32'(count_m[w] == 0));
  endtask

  initial begin
    int len, c, plots, op;
    reset       = 1'b1;
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    cmd_op      = 2'd0;
    cmd_idx_bus = 7'd0;
    query_x     = 8'd50;
    query_y     = 7'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_plot", a_plot, 0);
    check("rst_done", a_done, 0);
    check("rst_xyc", {a_x, a_y, a_c}, 0);
    check("rst_ready", a_ready, 1);
    check("rst_count", a_count, 0);
    check("rst_cleared", a_cleared, 1);
    chk_query(0, "q_rst");

    issue(0, OP_INIT_ALL, 0);
    set_query(50, 9);
    chk_query(0, "q_50_9_before");
    issue(0, OP_KILL, 13);
    chk_query(0, "q_50_9_after");
    issue(0, OP_KILL, 13);
    issue(0, OP_KILL, 45);
    set_query(20, 5);
    chk_query(0, "q_20_5_gap");
    set_query(20, 3);
    chk_query(0, "q_20_3");

    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) != 0) ? int'(OP_KILL) : int'(OP_REVIVE);
      issue(0, op, $urandom_range(0, 47));
      for (int k = 0; k < 3; k++) begin
        set_query($urandom_range(0, 175), $urandom_range(0, 40));
        chk_query(0, "q_rand_a");
      end
    end
    issue(0, OP_REDRAW, 0);

    set_query(50, 9);
    issue(1, OP_INIT_ALL, 0);
    issue(1, OP_KILL, 75);
    issue(1, OP_KILL, 3);
    issue(1, OP_REVIVE, 3);
    issue(1, OP_KILL, 13);
    issue(1, OP_REDRAW, 0);
    set_query(20, 60);
    chk_query(1, "q_b_gap_row7");
    set_query(20, 58);
    chk_query(1, "q_b_row7");
    set_query(85, 57);
    chk_query(1, "q_b_dead75");

    // Reset lands in the middle of a full draw of field a.
    @(negedge clk);
    model_cmd(0, OP_INIT_ALL, 0, len);
    cmd_op  = 2'(OP_INIT_ALL);
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    plots   = 0;
    c       = 0;
    while (plots < 1000 && c < 3000) begin
      if (a_plot === 1'b1) plots++;
      if (plots < 1000) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    check("plots_before_reset", plots, 1000);
    @(negedge clk);
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 80; b++) alive_m[w][b] = 1'b0;
      count_m[w] = 0;
    end
    @(posedge clk);
    #1;
    check("mid_rst_plot", a_plot, 0);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_ready", a_ready, 1);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_cleared", a_cleared, 1);
    check("mid_rst_count_b", b_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_plot", a_plot, 0);
    chk_query(0, "q_post_rst");

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end

endmodule
